// File: rtl/data_c_pack.sv
// data_c_pack: packs RATIO narrow input beats LSB-first into one wide output word.
// Optional idle-timeout flush of partial words when DATA_C_PACK_FLUSH_EN is defined.
module data_c_pack #(
  parameter int ISIZE = 8,
  parameter int RATIO = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [ISIZE-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [ISIZE*RATIO-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(RATIO+1)-1:0] out_cnt
);
  localparam int CW = $clog2(RATIO);
  localparam int OCW = $clog2(RATIO+1);
  if (RATIO < 2 || RATIO > 16 || TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_param
    $error("data_c_pack: parameter out of range");
  end
  logic [CW-1:0] cnt;
  logic [ISIZE*RATIO-1:0] gather, word;
  logic in_xfer, complete, flush;
  assign in_ready = !(cnt == CW'(RATIO-1) && out_valid && !out_ready);
  assign in_xfer = in_valid && in_ready;
  assign complete = in_xfer && cnt == CW'(RATIO-1);
  always_comb begin
    word = gather;
    word[cnt*ISIZE +: ISIZE] = in_data;
  end
`ifdef DATA_C_PACK_FLUSH_EN
  localparam int IW = $clog2(TIMEOUT+1);
  logic [IW-1:0] idle;
  logic out_free;
  assign out_free = !out_valid || out_ready;
  // idle saturates so a stalled flush keeps waiting for the output register
  assign flush = cnt != '0 && !in_xfer && idle >= IW'(TIMEOUT-1) && out_free;
  always_ff @(posedge clock)
    if (rst || in_xfer || cnt == '0 || flush) idle <= '0;
    else if (idle != IW'(TIMEOUT)) idle <= idle + 1'b1;
`else
  assign flush = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt <= '0;
      gather <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_cnt <= '0;
    end else if (complete) begin
      out_data <= word;
      out_valid <= 1'b1;
      out_cnt <= OCW'(RATIO);
      cnt <= '0;
      gather <= '0;
    end else if (flush) begin
      out_data <= gather;
      out_valid <= 1'b1;
      out_cnt <= OCW'(cnt);
      cnt <= '0;
      gather <= '0;
    end else begin
      if (in_xfer) begin
        gather <= word;
        cnt <= cnt + 1'b1;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_data_c_pack.sv
// tb_data_c_pack: table-driven checks of data_c_pack (ISIZE=8, RATIO=4, TIMEOUT=16).
module tb_data_c_pack;
  logic clock = 1'b0, rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data;
  logic [31:0] out_data;
  logic [2:0] out_cnt;
  int errors = 0, checks = 0;

  data_c_pack #(.ISIZE(8), .RATIO(4), .TIMEOUT(16)) dut (
    .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic r, iv;
    logic [7:0] id;
    logic ordy, irdy, ov;
    logic [31:0] od;
    logic [2:0] oc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, iv, input logic [7:0] id, input logic ordy, irdy, ov,
                     input logic [31:0] od, input logic [2:0] oc);
    vec_t v;
    v.r = r; v.iv = iv; v.id = id; v.ordy = ordy; v.irdy = irdy; v.ov = ov; v.od = od; v.oc = oc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, iv, input logic [7:0] id, input logic ordy);
    rst = r; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  initial begin
    int n;
    drive(1, 0, 0, 1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("reset_ov", out_valid, 0);
    chk("reset_od", out_data, 0);
    chk("reset_oc", out_cnt, 0);
    drive(0, 0, 0, 1);
    #1 chk("reset_irdy", in_ready, 1);
    // basic word
    add(0,1,8'h11,1,1,0,0,0); add(0,1,8'h22,1,1,0,0,0); add(0,1,8'h33,1,1,0,0,0);
    add(0,1,8'h44,1,1,1,32'h44332211,4); add(0,0,0,1,1,0,0,0);
    // streaming 12 beats
    for (int i = 1; i <= 12; i++)
      add(0,1,8'(i),1,1,(i%4)==0,(i%4)==0 ? {8'(i),8'(i-1),8'(i-2),8'(i-3)} : 32'h0,4);
    add(0,0,0,1,1,0,0,0);
    // stall while a word is pending
    add(0,1,8'h11,0,1,0,0,0); add(0,1,8'h22,0,1,0,0,0); add(0,1,8'h33,0,1,0,0,0);
    add(0,1,8'h44,0,1,1,32'h44332211,4);
    add(0,1,8'h55,0,1,1,32'h44332211,4); add(0,1,8'h66,0,1,1,32'h44332211,4);
    add(0,1,8'h77,0,1,1,32'h44332211,4);
    add(0,1,8'h88,0,0,1,32'h44332211,4); add(0,1,8'h88,0,0,1,32'h44332211,4);
    add(0,1,8'h88,1,1,1,32'h88776655,4); add(0,0,0,1,1,0,0,0);
    // reset mid-word discards partial beats
    add(0,1,8'hAA,1,1,0,0,0); add(0,1,8'hBB,1,1,0,0,0); add(0,1,8'hCC,1,1,0,0,0);
    add(1,0,0,1,1,0,0,0);
    add(0,1,8'h01,1,1,0,0,0); add(0,1,8'h02,1,1,0,0,0); add(0,1,8'h03,1,1,0,0,0);
    add(0,1,8'h04,1,1,1,32'h04030201,4); add(0,0,0,1,1,0,0,0);
    // reset discards a stalled output word
    add(0,1,8'h11,0,1,0,0,0); add(0,1,8'h22,0,1,0,0,0); add(0,1,8'h33,0,1,0,0,0);
    add(0,1,8'h44,0,1,1,32'h44332211,4);
    add(1,0,0,0,1,0,0,0); add(0,0,0,1,1,0,0,0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      #1 chk($sformatf("row%0d_irdy", i), in_ready, vecs[i].irdy);
      @(posedge clock); #1;
      chk($sformatf("row%0d_ov", i), out_valid, vecs[i].ov);
      if (vecs[i].ov || vecs[i].r) begin
        chk($sformatf("row%0d_od", i), out_data, vecs[i].od);
        chk($sformatf("row%0d_oc", i), out_cnt, vecs[i].oc);
      end
    end
    // partial word followed by idle cycles
    drive(0, 1, 8'hAA, 1); @(posedge clock); #1;
    drive(0, 1, 8'hBB, 1); @(posedge clock); #1;
    drive(0, 0, 0, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
`ifdef DATA_C_PACK_FLUSH_EN
    chk("flush_ov", out_valid, 1);
    chk("flush_delay", n, 16);
    chk("flush_od", out_data, 32'h0000BBAA);
    chk("flush_oc", out_cnt, 2);
    @(posedge clock); #1;
    chk("flush_clear", out_valid, 0);
`else
    chk("noflush_ov", out_valid, 0);
    drive(0, 1, 8'hCC, 1); @(posedge clock); #1;
    drive(0, 1, 8'hDD, 1); @(posedge clock); #1;
    chk("held_ov", out_valid, 1);
    chk("held_od", out_data, 32'hDDCCBBAA);
    chk("held_oc", out_cnt, 4);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_c_pack.md
DATA_C_PACK -- requirements
Module: data_c_pack

Interface
REQ-001 Parameter ISIZE, default 8, width of one input beat in bits.
REQ-002 Parameter RATIO, default 4, input beats per output word; legal range 2..16.
REQ-003 Parameter TIMEOUT, default 16, idle cycles before a partial word is flushed; legal range 2..1023; used only with DATA_C_PACK_FLUSH_EN.
REQ-004 clock  input  1  single clock; every register updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  ISIZE  input beat.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts an input beat.
REQ-009 out_data  output  ISIZE*RATIO  packed word; lane k occupies bits [k*ISIZE +: ISIZE].
REQ-010 out_valid  output  1  packed word valid.
REQ-011 out_ready  input  1  downstream accepts the packed word.
REQ-012 out_cnt  output  $clog2(RATIO+1)  number of valid lanes in out_data, counted from lane 0.

Function
REQ-013 Input transfer is in_valid && in_ready; output transfer is out_valid && out_ready.
REQ-014 Lane counter cnt (0..RATIO-1) SHALL select the lane written by each input transfer; lane 0 is filled first (LSB-first).
REQ-015 An input transfer with cnt < RATIO-1 SHALL store the beat and increment cnt.
REQ-016 An input transfer with cnt == RATIO-1 SHALL load out_data with the completed word, set out_valid and out_cnt=RATIO on the next edge, clear cnt, and clear the gather buffer.
REQ-017 The output register SHALL hold out_data/out_cnt stable while out_valid && !out_ready.
REQ-018 in_ready SHALL be low only when cnt == RATIO-1 && out_valid && !out_ready; beats that do not complete a word are accepted while the output stalls.
REQ-019 Completing a word in the same cycle as an output transfer SHALL reload the output register with no bubble; sustained in_valid with out_ready high gives one output word every RATIO cycles.
REQ-020 out_valid SHALL clear on an output transfer unless a new word is loaded in the same cycle.
REQ-021 Unfilled lanes of any emitted word SHALL be zero.
REQ-022 Latency: the completing input beat appears in out_data one cycle after its transfer.
REQ-023 The block SHALL never drop, duplicate or reorder beats.

Reset
REQ-024 While rst is high on a rising edge: out_valid=0, out_data=0, out_cnt=0, cnt=0, gather buffer=0, idle counter=0.
REQ-025 in_ready SHALL be 1 in the first cycle after rst deasserts; reset mid-word SHALL discard the partial word and any unaccepted output word.

Configuration
REQ-026 Macro DATA_C_PACK_FLUSH_EN defined: an idle counter SHALL count cycles with cnt != 0 and no input transfer; it SHALL clear on any input transfer or when cnt == 0.
REQ-027 With the macro, when the idle counter reaches TIMEOUT and the output register is free (!out_valid, or out_ready high), the partial word SHALL be emitted with out_cnt=cnt and zero padding, and cnt and the idle counter SHALL clear.
REQ-028 With the macro, if an input transfer occurs in the flush cycle, the input transfer SHALL take precedence and no flush SHALL occur that cycle.
REQ-029 With the macro, if the output is stalled at timeout, the flush SHALL wait until the output register is free.
REQ-030 Macro not defined: no idle counter; partial words are held indefinitely; out_cnt is always RATIO when out_valid is high.

Verification (ISIZE=8, RATIO=4, TIMEOUT=16)
REQ-031 Beats 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1 -> one cycle later out_valid=1, out_data=0x44332211, out_cnt=4.
REQ-032 Continuous in_valid over 12 beats 0x01..0x0C, out_ready=1 -> words 0x04030201, 0x08070605, 0x0C0B0A09 at 4-cycle spacing; in_ready stays 1.
REQ-033 Word pending with out_ready=0, next beats 0x55,0x66,0x77 -> all accepted, 4th beat 0x88 sees in_ready=0 until out_ready=1; the second word is 0x88776655.
REQ-034 With flush enabled: beats 0xAA,0xBB, then idle -> 16 idle cycles later out_data=0x0000BBAA, out_cnt=2; without the macro no output appears.
REQ-035 rst pulsed after 3 beats, then 4 beats 0x01..0x04 -> output 0x04030201 only; no residue from pre-reset beats.
